// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NORM = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int DEF_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    // Quotient reported on a divide by zero.
    localparam logic [DEF_WIDTH-1:0] ZDIV_QUO = '1;

endpackage

// File: rtl/div_magnitude.sv
// Conditional two's complement: used for operand magnitudes and for the final sign fix-up.
module div_magnitude #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value) + WIDTH'(1'b1) : value;

endmodule

// File: rtl/div_32bit_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock; LO = quotient, HI = remainder.
// Optional DIV_UNSIGNED_EN adds an unsigned_op input selecting unsigned division.
module div_32bit_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
`ifdef DIV_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ZQ = {WIDTH{ZDIV_QUO[0]}};

    state_t           state, nxt;
    logic [WIDTH-1:0] ra_q, rb_q, quo, dvs, hi_q, lo_q;
    logic [WIDTH:0]   rem;
    logic [WIDTH+1:0] shifted, trial;
    logic [CW-1:0]    cnt;
    logic             sa, sb, uns, dbz_q, uns_in;
    logic [WIDTH-1:0] ra_mag, rb_mag, quo_fix, rem_fix;

`ifdef DIV_UNSIGNED_EN
    assign uns_in = unsigned_op;
`else
    assign uns_in = 1'b0;
`endif

    div_magnitude #(.WIDTH(WIDTH)) u_mag_a (.value(ra_q), .neg(sa & ~uns), .result(ra_mag));
    div_magnitude #(.WIDTH(WIDTH)) u_mag_b (.value(rb_q), .neg(sb & ~uns), .result(rb_mag));
    div_magnitude #(.WIDTH(WIDTH)) u_fix_q (.value(quo), .neg((sa ^ sb) & ~uns), .result(quo_fix));
    // Remainder takes the dividend's sign so that Ra = LO*Rb + HI holds.
    div_magnitude #(.WIDTH(WIDTH)) u_fix_r (.value(rem[WIDTH-1:0]), .neg(sa & ~uns), .result(rem_fix));

    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs};

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = NORM;
            NORM:    nxt = (rb_q == '0) ? FIX : ITER;
            ITER:    if (cnt == CW'(1)) nxt = FIX;
            FIX:     nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == NORM) || (state == ITER) || (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ra_q  <= '0;
            rb_q  <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            uns   <= 1'b0;
            quo   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ra_q <= Ra;
                    rb_q <= Rb;
                    sa   <= Ra[WIDTH-1];
                    sb   <= Rb[WIDTH-1];
                    uns  <= uns_in;
                end
                NORM: begin
                    quo <= ra_mag;
                    dvs <= rb_mag;
                    rem <= '0;
                    cnt <= CW'(WIDTH);
                end
                ITER: begin
                    cnt <= cnt - CW'(1);
                    if (!trial[WIDTH+1]) begin
                        rem <= trial[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (rb_q == '0) begin
                        lo_q  <= ZQ;
                        hi_q  <= ra_q;
                        dbz_q <= 1'b1;
                    end else begin
                        lo_q  <= quo_fix;
                        hi_q  <= rem_fix;
                        dbz_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI          = hi_q;
    assign LO          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Randomized self-checking bench for div_32bit_seq against an arithmetic reference model.
module tb_div_32bit_seq;

    logic        clk = 1'b0, clear = 1'b0, start = 1'b0;
    logic [31:0] Ra = '0, Rb = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;
    bit          uo = 1'b0;
    int          total = 0, bad = 0;

`ifdef DIV_UNSIGNED_EN
    logic unsigned_op;
    assign unsigned_op = uo;
`endif

    div_32bit_seq #(.WIDTH(32)) dut (
        .clk(clk), .clear(clear), .start(start),
`ifdef DIV_UNSIGNED_EN
        .unsigned_op(unsigned_op),
`endif
        .Ra(Ra), .Rb(Rb), .busy(busy), .done(done),
        .HI(HI), .LO(LO), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit u,
                                  output logic [31:0] q, output logic [31:0] r, output bit z);
        int sa_, sb_;
        sa_ = a;
        sb_ = b;
        z = 1'b0;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else if (u) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
        end else begin
            q = sa_ / sb_; r = sa_ % sb_;
        end
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit u);
        @(negedge clk);
        Ra = a; Rb = b; uo = u; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit u, input bit repulse);
        logic [31:0] eq, er;
        bit          ez;
        int          n, gaps, extra;
        model(a, b, u, eq, er, ez);
        issue(a, b, u);
        chk("busy_start", {31'b0, busy}, 32'd1);
        n = 0; gaps = 0; extra = 0;
        while (1) begin
            @(posedge clk);
            #1 start = 1'b0;
            n++;
            if (done || n >= 100) break;
            if (!busy) gaps++;
            if (repulse && n == 5) begin
                Ra = 32'd1; Rb = 32'd1; start = 1'b1;
            end
        end
        chk("latency", 32'(n), (b == 0) ? 32'd2 : 32'd34);
        chk("busy_gap", 32'(gaps), 32'd0);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        chk("LO", LO, eq);
        chk("HI", HI, er);
        chk("dbz", {31'b0, div_by_zero}, {31'b0, ez});
        // A start in the DONE cycle must be dropped.
        Ra = 32'd5; Rb = 32'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("done_start_ignored", {31'b0, busy}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1 if (done || busy) extra++;
        end
        chk("no_extra_done", 32'(extra), 32'd0);
        chk("LO_hold", LO, eq);
        chk("HI_hold", HI, er);
    endtask

    initial begin
        int dn;
        logic [31:0] a, b;
        bit u;

        #2 clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk) clear = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b0);
        run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0);
        run_op(32'd9, 32'd3, 1'b0, 1'b0);

        // Abort mid-operation with clear between edges 10 and 11.
        issue(32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #2 clear = 1'b1;
        #1;
        chk("clr_LO", LO, 32'd0);
        chk("clr_HI", HI, 32'd0);
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_done", {31'b0, done}, 32'd0);
        @(negedge clk) clear = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        chk("clr_no_done", 32'(dn), 32'd0);
        run_op(32'd50, 32'd5, 1'b0, 1'b0);

        run_op(32'd100, 32'd7, 1'b0, 1'b1);

`ifdef DIV_UNSIGNED_EN
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'd0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
`ifdef DIV_UNSIGNED_EN
            u = 1'($urandom_range(0, 1));
`else
            u = 1'b0;
`endif
            run_op(a, b, u, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
